regfile_arbiter: RTL and testbench
==================================

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_LOCK, default 8: maximum consecutive cycles one requester may hold a lock.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clock  in  1  single clock, all state updates on rising edge.
REQ-004 ctrl_reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  2  bit i: requester i presents an access (0 = core, 1 = debug loader).
REQ-006 req_we  in  2  bit i: 1 = write access, 0 = read access.
REQ-007 req_lock  in  2  bit i: keep grant after this transfer.
REQ-008 req_waddr  in  10  write register, [5i+4:5i].
REQ-009 req_wdata  in  64  write data, [32i+31:32i].
REQ-010 req_raddrA, req_raddrB  in  10 each  read registers, [5i+4:5i].
REQ-011 req_ready  out  2  bit i: requester i is granted this cycle.
REQ-012 rsp_valid  out  2  bit i: read response for requester i.
REQ-013 rsp_dataA, rsp_dataB  out  32 each  registered read data.
REQ-014 ctrl_writeEnable  out  1; ctrl_writeReg  out  5; data_writeReg  out  32: regfile write port.
REQ-015 ctrl_readRegA, ctrl_readRegB  out  5 each; data_readRegA, data_readRegB  in  32 each: regfile read ports.
REQ-016 lock_active  out  1  state is LOCK0 or LOCK1.

Function
REQ-017 States SHALL be IDLE, LOCK0, LOCK1; at most one req_ready bit high in any cycle.
REQ-018 A transfer SHALL occur when req_valid[i] and req_ready[i] are both 1; req_ready is combinational from state and req_valid.
REQ-019 IDLE, single valid: that requester ready; no valid: req_ready = 2'b00.
REQ-020 LOCKi: only requester i ready (when valid); other requester stalls.
REQ-021 Granted requester's addresses/data SHALL drive regfile ports combinationally in the transfer cycle; with no transfer, ctrl_readRegA/B = 0 and ctrl_writeEnable = 0.
REQ-022 ctrl_writeEnable = 1 only for accepted write with waddr != 0; writes to r0 dropped silently.
REQ-023 Accepted read: rsp_valid[i] = 1 exactly one cycle later, rsp_dataA/B = data_readRegA/B sampled at transfer edge; rsp data holds until next read response.
REQ-024 Accepted write SHALL produce no rsp_valid.
REQ-025 Transfer with lock=1 from IDLE or LOCKi -> LOCKi; transfer with lock=0 in LOCKi -> IDLE.
REQ-026 Lock cycle counter SHALL clear on LOCK entry, increment every LOCK cycle; when it reaches MAX_LOCK-1, next state IDLE regardless of lock.
REQ-027 After forced release from LOCKi, next IDLE arbitration SHALL favour the other requester if valid, regardless of configuration.
REQ-028 LOCKi with req_valid[i]=0 SHALL remain locked (counter still runs).
REQ-029 No write-to-read forwarding; same-cycle behaviour is the regfile's.

Reset
REQ-030 ctrl_reset SHALL force immediately: state IDLE, counter 0, last-grant pointer = 1 (req0 favoured next), rsp_valid 0, rsp_dataA/B 0.
REQ-031 Reset mid-lock SHALL abandon lock and any pending response without emitting rsp_valid.

Configuration
REQ-032 Macro REGARB_ROUND_ROBIN_EN defined: both valid in IDLE -> grant requester not granted last; pointer updates on every transfer.
REQ-033 Macro undefined: both valid in IDLE -> req0 always granted (fixed priority), except REQ-027.

Verification
REQ-034 Reset, req0 write r5=0xFFFF then read A=r5 -> ctrl_writeEnable 1, writeReg 5; next read rsp_valid=2'b01 one cycle later, rsp_dataA=0xFFFF.
REQ-035 req1 write r0=0x1234 -> ctrl_writeEnable 0, req_ready[1]=1, no rsp_valid.
REQ-036 Both valid 4 cycles, no lock -> with RR grants 0,1,0,1; without macro 0,0,0,0.
REQ-037 req1 lock=1 held, req0 valid, MAX_LOCK=8 -> req1 ready 8 cycles, lock_active 1, then req0 granted next IDLE cycle.
REQ-038 req0 lock then lock=0 at 3rd transfer -> IDLE after 3rd, lock_active falls.
REQ-039 ctrl_reset asserted during LOCK1 with read in flight -> lock_active 0, rsp_valid 0 immediately.

Source files
------------

// File: rtl/regfile_arbiter_if.sv
// regfile_arbiter_if: request/response bundle between the two requesters and regfile_arbiter.
interface regfile_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [1:0]  req_lock;
    logic [9:0]  req_waddr;
    logic [63:0] req_wdata;
    logic [9:0]  req_raddrA;
    logic [9:0]  req_raddrB;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_dataA;
    logic [31:0] rsp_dataB;
    modport master (
        output req_valid, req_we, req_lock, req_waddr, req_wdata, req_raddrA, req_raddrB,
        input  req_ready, rsp_valid, rsp_dataA, rsp_dataB
    );
    modport slave (
        input  req_valid, req_we, req_lock, req_waddr, req_wdata, req_raddrA, req_raddrB,
        output req_ready, rsp_valid, rsp_dataA, rsp_dataB
    );
endinterface

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-requester arbiter with bounded lockable grants in front of a 2R1W regfile.
// Define REGARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise req0 has fixed priority.
module regfile_arbiter #(
    parameter int MAX_LOCK = 8
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    regfile_arbiter_if.slave bus,
    output logic             ctrl_writeEnable,
    output logic [4:0]       ctrl_writeReg,
    output logic [31:0]      data_writeReg,
    output logic [4:0]       ctrl_readRegA,
    output logic [4:0]       ctrl_readRegB,
    input  logic [31:0]      data_readRegA,
    input  logic [31:0]      data_readRegB,
    output logic             lock_active
);
    localparam int CW = $clog2(MAX_LOCK + 1);
    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic last, fav, fav_sel, fav_nxt, fav_sel_nxt;
    logic g, idle_g, locked, xfer, rd, rel;
    logic [1:0] ready;
    logic [4:0] waddr;
    always_comb begin
        // fav steers the first IDLE arbitration after a forced lock release
`ifdef REGARB_ROUND_ROBIN_EN
        idle_g = &bus.req_valid ? (fav ? fav_sel : ~last) : bus.req_valid[1];
`else
        idle_g = &bus.req_valid ? (fav ? fav_sel : 1'b0) : bus.req_valid[1];
`endif
        locked = state != IDLE;
        g = locked ? (state == LOCK1) : idle_g;
        ready = bus.req_valid & (g ? 2'b10 : 2'b01);
        xfer = |ready;
        rd = xfer && !bus.req_we[g];
        waddr = g ? bus.req_waddr[9:5] : bus.req_waddr[4:0];
        ctrl_writeEnable = xfer && bus.req_we[g] && waddr != 5'd0;
        ctrl_writeReg = xfer ? waddr : 5'd0;
        data_writeReg = xfer ? (g ? bus.req_wdata[63:32] : bus.req_wdata[31:0]) : 32'd0;
        ctrl_readRegA = xfer ? (g ? bus.req_raddrA[9:5] : bus.req_raddrA[4:0]) : 5'd0;
        ctrl_readRegB = xfer ? (g ? bus.req_raddrB[9:5] : bus.req_raddrB[4:0]) : 5'd0;
        rel = locked && (int'(cnt) + 1 >= MAX_LOCK - 1);
        state_nxt = locked ? ((rel || (xfer && !bus.req_lock[g])) ? IDLE : state)
                           : ((xfer && bus.req_lock[g]) ? (g ? LOCK1 : LOCK0) : IDLE);
        cnt_nxt = (locked && state_nxt != IDLE) ? cnt + CW'(1) : '0;
        fav_nxt = rel ? 1'b1 : (!locked && |bus.req_valid) ? 1'b0 : fav;
        fav_sel_nxt = rel ? ~g : fav_sel;
    end
    assign bus.req_ready = ready;
    assign lock_active = locked;
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state <= IDLE;
            cnt <= '0;
            last <= 1'b1;
            fav <= 1'b0;
            fav_sel <= 1'b0;
            bus.rsp_valid <= 2'b00;
            bus.rsp_dataA <= 32'd0;
            bus.rsp_dataB <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            fav <= fav_nxt;
            fav_sel <= fav_sel_nxt;
            if (xfer) last <= g;
            bus.rsp_valid <= rd ? ready : 2'b00;
            if (rd) begin
                bus.rsp_dataA <= data_readRegA;
                bus.rsp_dataB <= data_readRegB;
            end
        end
    end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: randomized + directed scoreboard bench for regfile_arbiter with a behavioural model.
module tb_regfile_arbiter;
    localparam int ML = 8;
    logic clock = 1'b0;
    logic ctrl_reset = 1'b1;
    logic ctrl_writeEnable, lock_active;
    logic [4:0] ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
    logic [31:0] data_writeReg, data_readRegA, data_readRegB;
    logic [31:0] rf [32];
    logic [31:0] mrf [32];
    logic [31:0] hold_a, hold_b;
    int checks = 0, failures = 0, cyc = 0;
    int owner, lock_left, last, favour;
    typedef struct { int who; logic [31:0] a; logic [31:0] b; int due; } rsp_t;
    rsp_t q[$];

    regfile_arbiter_if bus();
    regfile_arbiter #(.MAX_LOCK(ML)) dut (
        .clock(clock), .ctrl_reset(ctrl_reset), .bus(bus),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .ctrl_readRegA(ctrl_readRegA),
        .ctrl_readRegB(ctrl_readRegB), .data_readRegA(data_readRegA),
        .data_readRegB(data_readRegB), .lock_active(lock_active)
    );

    always #5 clock = ~clock;
    assign data_readRegA = rf[ctrl_readRegA];
    assign data_readRegB = rf[ctrl_readRegB];
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (ctrl_writeEnable) rf[ctrl_writeReg] <= data_writeReg;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_grant(input logic [1:0] v);
        if (owner >= 0) return v[owner] ? owner : -1;
        if (v == 2'b00) return -1;
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        if (favour >= 0) return favour;
`ifdef REGARB_ROUND_ROBIN_EN
        return 1 - last;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        owner = -1;
        lock_left = 0;
        last = 1;
        favour = -1;
    endtask

    task automatic drive(input logic [1:0] v, we, lk, input logic [9:0] wa, ra, rb, input logic [63:0] wd);
        bus.req_valid = v;
        bus.req_we = we;
        bus.req_lock = lk;
        bus.req_waddr = wa;
        bus.req_raddrA = ra;
        bus.req_raddrB = rb;
        bus.req_wdata = wd;
    endtask

    task automatic step(input logic [1:0] v, we, lk, input logic [9:0] wa, ra, rb, input logic [63:0] wd);
        int g;
        logic ewe;
        @(posedge clock);
        #1;
        drive(v, we, lk, wa, ra, rb, wd);
        #1;
        g = exp_grant(v);
        chk("req_ready", bus.req_ready, g < 0 ? 0 : (g == 1 ? 2 : 1));
        chk("lock_active", lock_active, owner >= 0);
        ewe = g >= 0 && we[g] && wa[5*g +: 5] != 5'd0;
        chk("write_en", ctrl_writeEnable, ewe);
        if (ewe) begin
            chk("write_reg", ctrl_writeReg, wa[5*g +: 5]);
            chk("write_data", data_writeReg, wd[32*g +: 32]);
            mrf[wa[5*g +: 5]] = wd[32*g +: 32];
        end
        if (g >= 0 && !we[g])
            q.push_back('{who: g, a: mrf[ra[5*g +: 5]], b: mrf[rb[5*g +: 5]], due: cyc + 1});
        if (g < 0) chk("idle_raddr", {ctrl_readRegA, ctrl_readRegB}, 0);
        if (owner >= 0) begin
            lock_left--;
            if (lock_left == 0) begin
                favour = 1 - owner;
                owner = -1;
            end else if (g >= 0 && !lk[g]) owner = -1;
        end else begin
            if (v != 2'b00) favour = -1;
            if (g >= 0 && lk[g]) begin
                owner = g;
                lock_left = ML - 1;
            end
        end
        if (g >= 0) last = g;
    endtask

    task automatic reset_mid();
        #1 ctrl_reset = 1'b1;
        #1;
        chk("rst_lock_active", lock_active, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        q.delete();
        model_reset();
        hold_a = 32'd0;
        hold_b = 32'd0;
        @(posedge clock);
        #1;
        chk("rst_rsp_after_edge", bus.rsp_valid, 0);
        chk("rst_rsp_dataA", bus.rsp_dataA, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        ctrl_reset = 1'b0;
    endtask

    // monitor: responses are due exactly one cycle after the accepting edge
    always @(negedge clock) begin
        rsp_t e;
        if (!ctrl_reset) begin
            if (q.size() != 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("rsp_valid", bus.rsp_valid, e.who == 1 ? 2'b10 : 2'b01);
                chk("rsp_dataA", bus.rsp_dataA, e.a);
                chk("rsp_dataB", bus.rsp_dataB, e.b);
                hold_a = e.a;
                hold_b = e.b;
            end else begin
                chk("rsp_quiet", bus.rsp_valid, 0);
                chk("rsp_holdA", bus.rsp_dataA, hold_a);
                chk("rsp_holdB", bus.rsp_dataB, hold_b);
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        hold_a = 32'd0;
        hold_b = 32'd0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        chk("reset_lock_active", lock_active, 0);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_data", {bus.rsp_dataA, bus.rsp_dataB}, 0);
        chk("reset_ready", bus.req_ready, 0);
        chk("reset_write_en", ctrl_writeEnable, 0);
        ctrl_reset = 1'b0;
        step(2'b01, 2'b01, 2'b00, 10'd5, 10'd0, 10'd0, 64'hFFFF);
        step(2'b01, 2'b00, 2'b00, 10'd0, 10'd5, 10'd0, 64'd0);
        step(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 10'd0, 64'd0);
        step(2'b10, 2'b10, 2'b00, 10'd0, 10'd0, 10'd0, {32'h1234, 32'h0});
        repeat (4) step(2'b11, 2'b00, 2'b00, 10'd0, {5'd5, 5'd5}, {5'd0, 5'd5}, 64'd0);
        repeat (10) step(2'b11, 2'b00, 2'b10, 10'd0, {5'd5, 5'd0}, {5'd0, 5'd5}, 64'd0);
        repeat (8) step(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 10'd0, 64'd0);
        step(2'b01, 2'b01, 2'b01, 10'd7, 10'd0, 10'd0, 64'hA5A5);
        step(2'b01, 2'b00, 2'b01, 10'd0, 10'd7, 10'd5, 64'd0);
        step(2'b01, 2'b00, 2'b00, 10'd0, 10'd5, 10'd7, 64'd0);
        step(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 10'd0, 64'd0);
        repeat (3) step(2'b10, 2'b00, 2'b10, 10'd0, {5'd7, 5'd0}, {5'd5, 5'd0}, 64'd0);
        reset_mid();
        for (int n = 0; n < 400; n++) begin
            logic [1:0] lk;
            lk = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            step(2'($urandom), 2'($urandom), lk,
                 {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
                 {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
                 {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
                 {$urandom, $urandom});
        end
        step(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 10'd0, 64'd0);
        repeat (3) @(posedge clock);
        #1;
        chk("rsp_drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
